mcycle_stall_unit: RTL

- Iterative multi-cycle multiply/divide unit in the Execute stage of the pipelined ARM core.
- Accepts a start request from the E-stage control path and computes over many cycles.
- Drives the Busy signal that the hazard logic routes to every pipeline register's Stall input, including the M→W data register.
- It is the producer of the stall protocol that the pipe registers consume: it holds the pipeline frozen until its result is ready, then releases it for exactly one advance.

---
 rtl/mcycle_stall_unit_pkg.sv | 27 ++
 rtl/mcycle_signfix.sv | 22 ++
 rtl/mcycle_stall_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/mcycle_stall_unit_pkg.sv
// mcycle_stall_unit_pkg: shared width, operation codes and FSM states for the multi-cycle unit
package mcycle_stall_unit_pkg;

    localparam int MC_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULS = 2'b01,
        OP_DIV  = 2'b10,
        OP_DIVS = 2'b11
    } mcycle_op_e;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        COMPUTING = 2'b01,
        DONE      = 2'b10
    } mcycle_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op inside {OP_DIV, OP_DIVS};
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op inside {OP_MULS, OP_DIVS};
    endfunction

endpackage

// File: rtl/mcycle_signfix.sv
// mcycle_signfix: conditional two's-complement negation of a word pair, either per word or as one 2W value
module mcycle_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    input  logic         neg_lo,
    input  logic         neg_hi,
    input  logic         neg_wide,
    output logic [W-1:0] lo_fix,
    output logic [W-1:0] hi_fix
);

    logic [2*W-1:0] wide;

    always_comb begin
        wide   = -{hi, lo};
        lo_fix = neg_wide ? wide[W-1:0]   : neg_lo ? -lo : lo;
        hi_fix = neg_wide ? wide[2*W-1:W] : neg_hi ? -hi : hi;
    end

endmodule

// File: rtl/mcycle_stall_unit.sv
// mcycle_stall_unit: iterative multiply/divide that stalls the pipeline until its registered result is ready
module mcycle_stall_unit
    import mcycle_stall_unit_pkg::*;
#(
    parameter int WIDTH = MC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_p,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mcycle_state_e    state, state_n;
    logic [CW-1:0]    count;
    logic             is_div, s1, s2, dz;
    logic [WIDTH-1:0] hi_q, lo_q, b_q, hi_n, lo_n;
    logic [WIDTH-1:0] mag1, mag2, fix_lo, fix_hi, dif;
    logic [WIDTH:0]   sum, shl;
    logic             ge, sgn;

    assign sgn = op_is_signed(MCycleOp);

    mcycle_signfix #(.W(WIDTH)) u_in_fix (
        .lo       (Operand1),
        .hi       (Operand2),
        .neg_lo   (sgn & Operand1[WIDTH-1]),
        .neg_hi   (sgn & Operand2[WIDTH-1]),
        .neg_wide (1'b0),
        .lo_fix   (mag1),
        .hi_fix   (mag2)
    );

    // Divide-by-zero leaves the dividend magnitude as remainder; re-signing it restores Operand1 exactly
    mcycle_signfix #(.W(WIDTH)) u_out_fix (
        .lo       (lo_n),
        .hi       (hi_n),
        .neg_lo   (is_div & (s1 ^ s2) & ~dz),
        .neg_hi   (is_div & s1),
        .neg_wide (~is_div & (s1 ^ s2)),
        .lo_fix   (fix_lo),
        .hi_fix   (fix_hi)
    );

    // Multiply: {hi,lo} is the shifting product; divide: hi is the partial remainder, lo shifts dividend out and quotient in
    always_comb begin
        sum  = {1'b0, hi_q} + {1'b0, b_q & {WIDTH{lo_q[0]}}};
        shl  = {hi_q, lo_q[WIDTH-1]};
        ge   = shl >= {1'b0, b_q};
        dif  = shl[WIDTH-1:0] - b_q;
        hi_n = is_div ? (ge ? dif : shl[WIDTH-1:0]) : sum[WIDTH:1];
        lo_n = is_div ? {lo_q[WIDTH-2:0], ge} : {sum[0], lo_q[WIDTH-1:1]};
    end

    always_comb begin
        state_n = IDLE;
        Busy    = 1'b0;
        case (state)
            IDLE: begin
                Busy    = Start;
                state_n = Start ? COMPUTING : IDLE;
            end
            COMPUTING: begin
                Busy    = 1'b1;
                state_n = (count == LAST) ? DONE : COMPUTING;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            count   <= '0;
            is_div  <= 1'b0;
            s1      <= 1'b0;
            s2      <= 1'b0;
            dz      <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            Result1 <= '0;
            Result2 <= '0;
        end else if (state == IDLE && Start) begin
            count  <= '0;
            is_div <= op_is_div(MCycleOp);
            s1     <= sgn & Operand1[WIDTH-1];
            s2     <= sgn & Operand2[WIDTH-1];
            dz     <= Operand2 == '0;
            hi_q   <= '0;
            lo_q   <= op_is_div(MCycleOp) ? mag1 : mag2;
            b_q    <= op_is_div(MCycleOp) ? mag2 : mag1;
        end else if (state == COMPUTING) begin
            count <= count + 1'b1;
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            if (count == LAST) begin
                Result1 <= fix_lo;
                Result2 <= fix_hi;
            end
        end
    end

endmodule
